branch_tag_ctrl: RTL
====================

// Module: branch_tag_ctrl
// PURPOSE
//  Owns the in-flight branch tags (0..MAX_PREDICT_DEPTH-1). Hands up to 2 tags per cycle to the decode pair and
//  snapshots the freelist head for each tag. On a mispredict it sequences freelist recovery: one branch_shootdown
//  broadcast per squashed tag, youngest first, then a single freelist head restore.
//  Sits beside uop decode; its busy output stalls decode.
// PARAMETERS
//  MAX_PREDICT_DEPTH       4  number of branch tags (ring size, power of 2)
//  MAX_PREDICT_DEPTH_BITS  2  $clog2(MAX_PREDICT_DEPTH)
//  FL_PTR_BITS             6  freelist head pointer width ($clog2(NUM_PREGS))
// PORTS
//  clk                  in   1        clock, all state on posedge
//  reset                in   1        synchronous, active-low (0 = reset)
//  alloc_req            in   2        branches in current decode pair needing tags (0..2; 3 illegal)
//  fl_head              in   FL_PTR   freelist head this cycle, snapshotted for each tag granted
//  alloc_ok             out  1        comb: request granted this cycle
//  alloc_tag_1          out  BITS     comb: tag for 1st branch (= tail)
//  alloc_tag_2          out  BITS     comb: tag for 2nd branch (= tail+1 mod depth)
//  resolve_valid        in   1        a branch resolved this cycle
//  resolve_tag          in   BITS     tag of resolving branch
//  resolve_mispredict   in   1        resolution was a mispredict
//  branch_shootdown     out  1        reg: squash broadcast valid
//  shootdown_branch_tag out  BITS     reg: tag being squashed
//  fl_restore_valid     out  1        reg: freelist must load fl_restore_head
//  fl_restore_head      out  FL_PTR   reg: snapshot head of mispredicted tag
//  busy                 out  1        comb: state != IDLE; decode must stall
//  num_free_tags        out  BITS+1   reg: tags not live
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, head=tail=0, live=0, done=0, num_free_tags=MAX_PREDICT_DEPTH.
//    All reg outputs 0. Reset mid-sequence aborts it; no restore is issued.
//  - Ring: live tags are head..tail-1 in ring order. age(t) = (t - head) mod depth; smaller is older.
//  - Alloc: alloc_ok = IDLE && alloc_req!=0 && num_free_tags>=alloc_req && !(resolve_valid&&resolve_mispredict).
//    If granted: snap[tail(+1)]<=fl_head, tail+=alloc_req, mark the tags live. alloc_req=0 gives alloc_ok=0.
//  - Resolve correct (any state, tag live and not squashed): done[tag]<=1. Each cycle, head retires up to 2
//    contiguous done tags starting at head. num_free_tags updates from the cycle's allocs and retires.
//    Same-cycle alloc and retire are both applied.
//  - Resolve on a non-live or already-squashed tag: ignored.
//  - Mispredict in IDLE on live tag M: go to SHOOT.
//    mp_tag<=M, cur<=tail-1. If M==tail-1, go straight to RESTORE.
//  - SHOOT: each cycle, branch_shootdown=1 and shootdown_branch_tag=cur. Clear live[cur].
//    If cur==mp_tag+1, go to RESTORE; else cur-=1.
//  - RESTORE (1 cycle): fl_restore_valid=1, fl_restore_head=snap[mp_tag], tail<=mp_tag.
//    This also frees the mispredicted tag. Then IDLE.
//  - Mispredict while in SHOOT/RESTORE:
//    - Tag older than mp_tag: restart SHOOT with mp_tag<=new tag and cur<=tail-1. Re-broadcast is allowed.
//    - Tag younger than or equal to mp_tag: ignored.
//  - Reg outputs deassert the cycle after their state exits. Latency from mispredict to restore =
//    (number of squashed tags)+1 cycles.
//  - Width rules: all tag arithmetic is mod MAX_PREDICT_DEPTH. num_free_tags is never above depth and never below 0.
// TESTING
//  1 reset=0 for 2 cycles -> busy=0, num_free_tags=4, branch_shootdown=0, fl_restore_valid=0.
//  2 alloc_req=2, fl_head=10 -> alloc_ok=1, tags 0,1, free=2.
//    Then alloc_req=2, fl_head=14 -> tags 2,3, free=0.
//    Then alloc_req=1 -> alloc_ok=0.
//  3 Tags 0-3 live; resolve 1 correct -> free stays 0.
//    Then resolve 0 correct -> free=2 next cycle, head=2.
//  4 Tags 0-3 live with snaps 10,11,14,15; mispredict tag 1:
//    - shootdown tags 3 then 2 on the next cycles
//    - then restore head 11
//    - busy for 3 cycles, then free=3.
//  5 Same setup; mispredict tag 2, then next cycle mispredict tag 1:
//    - shootdown 3, then 3, then 2
//    - then restore head 11.
//  6 Mispredict tag 0 with 4 live, reset=0 during SHOOT -> next cycle all outputs 0, free=4, no restore.

Source files
------------

// File: rtl/branch_tag_ctrl.sv
// Branch tag ring: hands out tags to the decode pair, snapshots the freelist
// head per tag, and sequences shootdown + freelist restore on a mispredict.
//
// Ports:
//   clk, reset (sync, active-low)
//   alloc_req/fl_head -> alloc_ok, alloc_tag_1/2      tag allocation
//   resolve_valid/tag/mispredict                      branch resolution
//   branch_shootdown, shootdown_branch_tag            squash broadcast (reg)
//   fl_restore_valid, fl_restore_head                 freelist restore (reg)
//   busy (stall decode), num_free_tags (reg)
module branch_tag_ctrl #(
  parameter int MAX_PREDICT_DEPTH      = 4,
  parameter int MAX_PREDICT_DEPTH_BITS = 2,
  parameter int FL_PTR_BITS            = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        alloc_req,
  input  logic [FL_PTR_BITS-1:0]            fl_head,
  output logic                              alloc_ok,
  output logic [MAX_PREDICT_DEPTH_BITS-1:0] alloc_tag_1,
  output logic [MAX_PREDICT_DEPTH_BITS-1:0] alloc_tag_2,
  input  logic                              resolve_valid,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] resolve_tag,
  input  logic                              resolve_mispredict,
  output logic                              branch_shootdown,
  output logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag,
  output logic                              fl_restore_valid,
  output logic [FL_PTR_BITS-1:0]            fl_restore_head,
  output logic                              busy,
  output logic [MAX_PREDICT_DEPTH_BITS:0]   num_free_tags
);

  localparam int D  = MAX_PREDICT_DEPTH;
  localparam int TW = MAX_PREDICT_DEPTH_BITS;
  localparam int FW = FL_PTR_BITS;
  localparam logic [TW-1:0] ONE = TW'(1);
  localparam logic [TW-1:0] TWO = TW'(2);

  typedef enum logic [1:0] {
    IDLE,
    SHOOT,
    RESTORE
  } state_e;

  state_e        state_q;
  logic [TW-1:0] mp_q, cur_q;
  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [D-1:0]  live_q, live_d;
  logic [D-1:0]  done_q, done_d;
  logic [FW-1:0] snap_q [D];
  logic [FW-1:0] snap_d [D];
  logic [TW:0]   free_q, free_d;

  logic          bsd_q, frv_q;
  logic [TW-1:0] sdt_q;
  logic [FW-1:0] frh_q;

  logic          mp_ev, rs_live, older, start;
  logic          shoot_last, do_restore;
  logic          ret0, ret1;
  logic [TW-1:0] tail_m1, head_p1, tail_p1;

  assign mp_ev   = resolve_valid && resolve_mispredict;
  assign rs_live = live_q[resolve_tag];
  assign tail_m1 = tail_q - ONE;
  assign tail_p1 = tail_q + ONE;
  assign head_p1 = head_q + ONE;

  // Age is distance from head; a smaller age is an older branch.
  assign older = rs_live &&
    ((resolve_tag - head_q) < (mp_q - head_q));

  // Begin (IDLE) or restart (busy, older tag) a recovery sequence.
  assign start = mp_ev && rs_live &&
    ((state_q == IDLE) || older);

  assign shoot_last = (cur_q == mp_q + ONE);
  assign do_restore = (state_q == RESTORE) &&
    !(mp_ev && older);

  assign alloc_ok = (state_q == IDLE) &&
    (alloc_req != 2'd0) &&
    (free_q >= (TW+1)'(alloc_req)) &&
    !mp_ev;

  always_comb begin
    live_d = live_q;
    done_d = done_q;
    snap_d = snap_q;
    head_d = head_q;
    tail_d = tail_q;
    ret0   = 1'b0;
    ret1   = 1'b0;

    if (resolve_valid && !resolve_mispredict && rs_live)
      done_d[resolve_tag] = 1'b1;

    if (state_q == SHOOT) begin
      live_d[cur_q] = 1'b0;
      done_d[cur_q] = 1'b0;
    end

    if (do_restore) begin
      tail_d        = mp_q;
      live_d[mp_q]  = 1'b0;
      done_d[mp_q]  = 1'b0;
    end

    // Retire sees this cycle's resolve so a head completion frees at once.
    ret0 = live_q[head_q] && done_d[head_q];
    ret1 = ret0 && live_q[head_p1] && done_d[head_p1];
    if (ret0) begin
      live_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_p1;
    end
    if (ret1) begin
      live_d[head_p1] = 1'b0;
      done_d[head_p1] = 1'b0;
      head_d          = head_q + TWO;
    end

    if (alloc_ok) begin
      live_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      snap_d[tail_q] = fl_head;
      if (alloc_req == 2'd2) begin
        live_d[tail_p1] = 1'b1;
        done_d[tail_p1] = 1'b0;
        snap_d[tail_p1] = fl_head;
      end
      tail_d = tail_q + TW'(alloc_req);
    end

    free_d = (TW+1)'(D - $countones(live_d));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      live_q <= '0;
      done_q <= '0;
      free_q <= (TW+1)'(D);
      for (int i = 0; i < D; i++)
        snap_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      live_q <= live_d;
      done_q <= done_d;
      free_q <= free_d;
      snap_q <= snap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mp_q    <= '0;
      cur_q   <= '0;
      bsd_q   <= 1'b0;
      sdt_q   <= '0;
      frv_q   <= 1'b0;
      frh_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mp_q  <= resolve_tag;
            cur_q <= tail_m1;
            if (resolve_tag == tail_m1) begin
              state_q <= RESTORE;
              frv_q   <= 1'b1;
              frh_q   <= snap_q[resolve_tag];
            end else begin
              state_q <= SHOOT;
              bsd_q   <= 1'b1;
              sdt_q   <= tail_m1;
            end
          end
        end
        SHOOT: begin
          if (start) begin
            mp_q  <= resolve_tag;
            cur_q <= tail_m1;
            sdt_q <= tail_m1;
          end else if (shoot_last) begin
            state_q <= RESTORE;
            bsd_q   <= 1'b0;
            sdt_q   <= '0;
            frv_q   <= 1'b1;
            frh_q   <= snap_q[mp_q];
          end else begin
            cur_q <= cur_q - ONE;
            sdt_q <= cur_q - ONE;
          end
        end
        RESTORE: begin
          frv_q <= 1'b0;
          frh_q <= '0;
          // An older mispredict here re-squashes from the unchanged tail.
          if (start) begin
            state_q <= SHOOT;
            mp_q    <= resolve_tag;
            cur_q   <= tail_m1;
            bsd_q   <= 1'b1;
            sdt_q   <= tail_m1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alloc_tag_1          = tail_q;
  assign alloc_tag_2          = tail_p1;
  assign branch_shootdown     = bsd_q;
  assign shootdown_branch_tag = sdt_q;
  assign fl_restore_valid     = frv_q;
  assign fl_restore_head      = frh_q;
  assign busy                 = (state_q != IDLE);
  assign num_free_tags        = free_q;

endmodule
